zigzag_ctrl: RTL and testbench



---
 rtl/zigzag_pkg.sv | 24 ++
 rtl/zigzag_ctrl_if.sv | 25 ++
 rtl/zigzag_bank_ram.sv | 33 +++
 rtl/zigzag_ctrl.sv | 123 ++++++++++++
 tb/tb_zigzag_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zigzag_pkg.sv
// Shared constants and types for the zigzag reorder controller:
// the raster address table indexed by zigzag position and the read FSM encoding.
package zigzag_pkg;

    localparam int BLK_SIZE = 64;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // ZZ[k] is the raster address (row*8+col) of zigzag position k.
    localparam logic [5:0] ZZ [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zigzag_ctrl_if.sv
// Coefficient stream bundle: raster-order input side and zigzag-order output side.
// The controller uses the slave view, the producer/consumer pair the master view.
interface zigzag_ctrl_if #(
    parameter int COEF_W = 12
);
    logic [COEF_W-1:0] din;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] dout;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_idx;
    logic              out_first;
    logic              out_last;

    modport slave (
        input  din, in_valid, out_ready,
        output in_ready, dout, out_valid, out_idx, out_first, out_last
    );

    modport master (
        output din, in_valid, out_ready,
        input  in_ready, dout, out_valid, out_idx, out_first, out_last
    );
endinterface

// File: rtl/zigzag_bank_ram.sv
// Two-bank coefficient buffer: one write port, one synchronous read port whose
// output register only loads on a read enable and otherwise holds its value.
module zigzag_bank_ram
    import zigzag_pkg::*;
#(
    parameter int COEF_W = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              wr_bank_i,
    input  logic [5:0]        wr_addr_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic              re_i,
    input  logic              rd_bank_i,
    input  logic [5:0]        rd_addr_i,
    output logic [COEF_W-1:0] rd_data_o
);

    logic [COEF_W-1:0] mem_q [2*BLK_SIZE];
    logic [COEF_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
        if (re_i) begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/zigzag_ctrl.sv
// Double-buffered zigzag reorder controller: fills one bank in raster order while
// the other drains in zigzag order, one coefficient per cycle on each side.
module zigzag_ctrl
    import zigzag_pkg::*;
#(
    parameter int COEF_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    zigzag_ctrl_if.slave   bus,
    output logic [1:0]     bank_full
);

    logic [5:0] wr_cnt_q;
    logic       wr_bank_q;
    logic       rd_bank_q;
    logic [5:0] k_q;
    logic [1:0] bank_full_q;
    logic [1:0] bank_full_d;
    logic [1:0] bank_set;
    logic [1:0] bank_clr;
    rd_state_t  state_q;
    logic       out_valid_q;
    logic [5:0] out_idx_q;
    logic       out_first_q;
    logic       out_last_q;

    logic wr_acc;
    logic wr_done;
    logic rd_en;
    logic rd_done;

    assign bus.in_ready = ena & ~bank_full_q[wr_bank_q];
    assign wr_acc       = bus.in_valid & bus.in_ready;
    assign wr_done      = wr_acc & (wr_cnt_q == 6'd63);
    assign rd_en        = ena & (state_q == READ) & (~out_valid_q | bus.out_ready);
    assign rd_done      = rd_en & (k_q == 6'd63);

    // Writer and reader always own different banks, so set and clear never collide.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_set[gi]    = wr_done & (wr_bank_q == 1'(gi));
            assign bank_clr[gi]    = rd_done & (rd_bank_q == 1'(gi));
            assign bank_full_d[gi] = (bank_full_q[gi] | bank_set[gi]) & ~bank_clr[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            k_q         <= '0;
            bank_full_q <= 2'b00;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (ena) begin
            if (wr_acc) begin
                wr_cnt_q <= wr_cnt_q + 6'd1;
                if (wr_done) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            bank_full_q <= bank_full_d;

            case (state_q)
                IDLE: begin
                    if (bank_full_q[rd_bank_q]) begin
                        state_q <= READ;
                        k_q     <= '0;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        k_q <= k_q + 6'd1;
                        // Chain straight into the next block when it is already waiting.
                        if (rd_done) begin
                            rd_bank_q <= ~rd_bank_q;
                            if (!bank_full_q[~rd_bank_q]) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (rd_en) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= k_q;
                out_first_q <= (k_q == 6'd0);
                out_last_q  <= (k_q == 6'd63);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    zigzag_bank_ram #(
        .COEF_W (COEF_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (wr_acc),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (wr_cnt_q),
        .wr_data_i (bus.din),
        .re_i      (rd_en),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (ZZ[k_q]),
        .rd_data_o (bus.dout)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bank_full     = bank_full_q;

endmodule

// File: tb/tb_zigzag_ctrl.sv
// Directed bench for zigzag_ctrl: single block, streaming, backpressure,
// clock-enable freeze and mid-operation reset, with an independent zigzag model.
module tb_zigzag_ctrl;

    localparam int CW = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] bank_full;

    zigzag_ctrl_if #(.COEF_W(CW)) bus();

    zigzag_ctrl #(.COEF_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .bus       (bus),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] din;
        logic [CW-1:0] exp_dout;
        logic [5:0]    exp_idx;
        logic          exp_first;
        logic          exp_last;
    } vec_t;

    typedef struct {
        logic [CW-1:0] d;
        logic [5:0]    idx;
        logic          f;
        logic          l;
    } orec_t;

    vec_t          vecs [64];
    logic [CW-1:0] in_q [$];
    orec_t         got  [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int in_acc   = 0;
    int rdy_mode = 0;
    int last64_cyc;
    int first_valid_cyc;
    int first_acc_cyc;
    int acc128_cyc;
    bit saw_full2;
    bit arm_bf_check;
    logic          prev_stall;
    logic [CW-1:0] prev_d;
    logic [5:0]    prev_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Zigzag order by walking anti-diagonals, alternating direction.
    function automatic int zz_ref(input int k);
        int order [64];
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    order[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    order[n] = r * 8 + (s - r);
                    n++;
                end
            end
        end
        return order[k];
    endfunction

    function automatic logic [CW-1:0] dval(input int seed, input int n);
        int v;
        v = seed + n;
        return v[CW-1:0];
    endfunction

    task automatic clear_tb();
        in_q.delete();
        got.delete();
        in_acc          = 0;
        last64_cyc      = -1;
        first_valid_cyc = -1;
        first_acc_cyc   = -1;
        acc128_cyc      = -1;
        saw_full2       = 1'b0;
        arm_bf_check    = 1'b0;
        prev_stall      = 1'b0;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        ena           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_tb();
    endtask

    task automatic monitor();
        orec_t rec;
        if (prev_stall) begin
            chk($sformatf("stall_hold_valid@%0d", cyc), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall_hold_dout@%0d", cyc), 32'(bus.dout), 32'(prev_d));
            chk($sformatf("stall_hold_idx@%0d", cyc), 32'(bus.out_idx), 32'(prev_idx));
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bank_full == 2'b11) begin
            saw_full2 = 1'b1;
            chk($sformatf("in_ready_both_full@%0d", cyc), 32'(bus.in_ready), 32'd0);
        end
        if (arm_bf_check && last64_cyc >= 0 && cyc == last64_cyc + 1)
            chk("bank_full_after_64th", 32'(bank_full), 32'b01);
        if (bus.in_valid && bus.in_ready) begin
            if (in_acc == 0)   first_acc_cyc = cyc;
            if (in_acc == 63)  last64_cyc    = cyc;
            if (in_acc == 127) acc128_cyc    = cyc;
        end
        if (bus.out_valid && bus.out_ready && ena) begin
            rec.d   = bus.dout;
            rec.idx = bus.out_idx;
            rec.f   = bus.out_first;
            rec.l   = bus.out_last;
            got.push_back(rec);
        end
        prev_stall = bus.out_valid & ~(bus.out_ready & ena);
        prev_d     = bus.dout;
        prev_idx   = bus.out_idx;
    endtask

    // Entered and left at posedge+1; outputs are sampled mid-cycle.
    task automatic one_cycle();
        logic acc_in;
        bus.in_valid = (in_q.size() > 0);
        bus.din      = (in_q.size() > 0) ? in_q[0] : '0;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus.out_ready = 1'b0;
        endcase
        #4;
        monitor();
        acc_in = bus.in_valid & bus.in_ready;
        @(posedge clk);
        #1;
        if (acc_in) begin
            void'(in_q.pop_front());
            in_acc++;
        end
        cyc++;
    endtask

    task automatic run(input int out_target, input int in_stop, input int max_cyc, input string name);
        int n;
        n = 0;
        while (got.size() < out_target && !(in_stop > 0 && in_acc >= in_stop)) begin
            if (n >= max_cyc) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: got %0d outputs %0d inputs required %0d / %0d",
                         name, got.size(), in_acc, out_target, in_stop);
                return;
            end
            one_cycle();
            n++;
        end
    endtask

    task automatic check_stream(input string name, input int seed, input int n);
        int b, k;
        logic [CW-1:0] e;
        chk({name, "_count"}, 32'(got.size() >= n), 32'd1);
        for (int i = 0; i < n && i < got.size(); i++) begin
            b = i / 64;
            k = i % 64;
            e = dval(seed, b * 64 + zz_ref(k));
            chk($sformatf("%s_out%0d", name, i),
                32'({got[i].d, got[i].idx, got[i].f, got[i].l}),
                32'({e, 6'(k), k == 0, k == 63}));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            vecs[i].din       = CW'(i);
            vecs[i].exp_dout  = CW'(zz_ref(i));
            vecs[i].exp_idx   = 6'(i);
            vecs[i].exp_first = (i == 0);
            vecs[i].exp_last  = (i == 63);
        end

        // Reset state
        apply_reset();
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_first", 32'(bus.out_first), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1;

        // Single block, table driven
        clear_tb();
        rdy_mode     = 0;
        arm_bf_check = 1'b1;
        for (int i = 0; i < 64; i++) in_q.push_back(vecs[i].din);
        run(64, 0, 400, "single");
        for (int i = 0; i < 64; i++) begin
            if (i < got.size())
                chk($sformatf("single_out%0d", i),
                    32'({got[i].d, got[i].idx, got[i].f, got[i].l}),
                    32'({vecs[i].exp_dout, vecs[i].exp_idx, vecs[i].exp_first, vecs[i].exp_last}));
            else
                chk($sformatf("single_missing%0d", i), 32'(got.size()), 32'd64);
        end
        chk("single_latency", 32'(first_valid_cyc - last64_cyc), 32'd3);

        // Streaming, four blocks
        apply_reset();
        rdy_mode = 0;
        for (int i = 0; i < 256; i++) in_q.push_back(dval(12'h100, i));
        run(256, 0, 2000, "stream");
        check_stream("stream", 12'h100, 256);
        chk("stream_first_two_blocks_unstalled", 32'(acc128_cyc - first_acc_cyc), 32'd127);

        // Backpressure 1,0,0,1
        apply_reset();
        rdy_mode = 1;
        for (int i = 0; i < 192; i++) in_q.push_back(dval(12'h200, i));
        run(192, 0, 3000, "bp");
        check_stream("bp", 12'h200, 192);
        chk("bp_saw_both_full", 32'(saw_full2), 32'd1);

        // Clock enable dropped with both sides mid-block
        apply_reset();
        rdy_mode = 0;
        for (int i = 0; i < 128; i++) in_q.push_back(dval(12'h300, i));
        run(128, 100, 1000, "ena_pre");
        begin
            logic          sv_valid;
            logic [CW-1:0] sv_dout;
            logic [5:0]    sv_idx;
            logic [1:0]    sv_bf;
            sv_valid = bus.out_valid;
            sv_dout  = bus.dout;
            sv_idx   = bus.out_idx;
            sv_bf    = bank_full;
            ena      = 1'b0;
            for (int i = 0; i < 5; i++) begin
                #1;
                chk($sformatf("ena_frz_valid%0d", i), 32'(bus.out_valid), 32'(sv_valid));
                chk($sformatf("ena_frz_dout%0d", i), 32'(bus.dout), 32'(sv_dout));
                chk($sformatf("ena_frz_idx%0d", i), 32'(bus.out_idx), 32'(sv_idx));
                chk($sformatf("ena_frz_bf%0d", i), 32'(bank_full), 32'(sv_bf));
                chk($sformatf("ena_frz_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
                one_cycle();
            end
            ena = 1'b1;
        end
        run(128, 0, 1000, "ena_post");
        check_stream("ena", 12'h300, 128);

        // Reset with block 2 at write 30 and block 1 at k=20
        apply_reset();
        for (int i = 0; i < 128; i++) in_q.push_back(dval(12'h400, i));
        rdy_mode = 2;
        run(999, 75, 500, "rst_a");
        rdy_mode = 0;
        run(999, 94, 500, "rst_b");
        chk("rst_prefix_count", 32'(got.size()), 32'd19);
        check_stream("rst_prefix", 12'h400, got.size());
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.din       = in_q.size() > 0 ? in_q[0] : '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_bank_full", 32'(bank_full), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        clear_tb();
        for (int i = 0; i < 64; i++) in_q.push_back(dval(12'h500, i));
        run(64, 0, 400, "post_rst");
        check_stream("post_rst", 12'h500, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
